// File: rtl/cavlc_bit_window.sv
// Bit-window buffer feeding the CAVLC coeff_token/level lookup stage.
// Bitstream words are appended behind the buffered bits. The next WIN_W
// unconsumed bits are presented MSB-first, and the LUT stage consumes a
// variable number of bits per cycle.
module cavlc_bit_window #(
  parameter int WORD_W  = 32,
  parameter int WIN_W   = 16,
  parameter int SHIFT_W = 5
) (
  input  logic               Clk,
  input  logic               nReset,
  input  logic               Flush,
  input  logic [WORD_W-1:0]  WordIn,
  input  logic               WordValid,
  output logic               WordReady,
  output logic [WIN_W-1:0]   Window,
  output logic               WindowValid,
  input  logic [SHIFT_W-1:0] Shift,
  input  logic               ShiftEn,
  output logic [6:0]         BitCount,
  output logic [31:0]        BitPos,
  output logic               ShiftErr
);

  localparam int BUF_W = 2 * WORD_W;
  localparam int CNT_W = 7;

  logic [BUF_W-1:0] bit_buf_q, bit_buf_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [31:0]      bit_pos_q, bit_pos_d;
  logic             shift_err_q, shift_err_d;

  logic             word_ready;
  logic             win_valid;
  logic             shift_acc;
  logic             word_acc;
  logic [CNT_W-1:0] shift_amt;
  logic [BUF_W-1:0] buf_shifted;
  logic [CNT_W-1:0] cnt_shifted;
  logic [BUF_W-1:0] word_ext;

  // Handshake flags derive only from registered state, so WordReady has no
  // combinational path from the inputs.
  always_comb begin
    word_ready = (bit_cnt_q <= CNT_W'(WORD_W));
    win_valid  = (bit_cnt_q >= CNT_W'(WIN_W));
  end

  // Next-state: the shift is applied first and the accepted word is then
  // appended directly behind the surviving bits. Flush overrides both.
  always_comb begin
    shift_amt   = CNT_W'(Shift);
    shift_acc   = ShiftEn && win_valid && (shift_amt <= CNT_W'(WIN_W));
    word_acc    = WordValid && word_ready;
    buf_shifted = shift_acc ? (bit_buf_q << shift_amt) : bit_buf_q;
    cnt_shifted = shift_acc ? (bit_cnt_q - shift_amt) : bit_cnt_q;
    word_ext    = {WordIn, {WORD_W{1'b0}}};

    bit_buf_d   = bit_buf_q;
    bit_cnt_d   = bit_cnt_q;
    bit_pos_d   = bit_pos_q;
    shift_err_d = shift_err_q;

    if (Flush) begin
      bit_buf_d   = '0;
      bit_cnt_d   = '0;
      bit_pos_d   = '0;
      shift_err_d = 1'b0;
    end else begin
      // Bits below the valid count are always zero, so OR-ing in the
      // realigned word is enough to append it.
      bit_buf_d   = buf_shifted | (word_acc ? (word_ext >> cnt_shifted) : '0);
      bit_cnt_d   = cnt_shifted + (word_acc ? CNT_W'(WORD_W) : '0);
      bit_pos_d   = bit_pos_q + (shift_acc ? 32'(Shift) : 32'd0);
      shift_err_d = shift_err_q | (ShiftEn && !shift_acc);
    end
  end

  // State registers, cleared asynchronously by reset.
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      bit_buf_q   <= '0;
      bit_cnt_q   <= '0;
      bit_pos_q   <= '0;
      shift_err_q <= 1'b0;
    end else begin
      bit_buf_q   <= bit_buf_d;
      bit_cnt_q   <= bit_cnt_d;
      bit_pos_q   <= bit_pos_d;
      shift_err_q <= shift_err_d;
    end
  end

  assign WordReady   = word_ready;
  assign WindowValid = win_valid;
  assign Window      = bit_buf_q[BUF_W-1 -: WIN_W];
  assign BitCount    = bit_cnt_q;
  assign BitPos      = bit_pos_q;
  assign ShiftErr    = shift_err_q;

endmodule
